// File: rtl/rw_arb_pkg.sv
// Shared types for the register write-port arbiter: width defaults,
// the MDU result record carried through the holding FIFO, and the slot source.
package rw_arb_pkg;

    localparam int unsigned RW_DATA_W = 32;
    localparam int unsigned RW_ADDR_W = 5;
    localparam int unsigned RW_NREG   = 32;

    typedef struct packed {
        logic [RW_ADDR_W-1:0] addr;
        logic [RW_DATA_W-1:0] data;
    } rw_result_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_FIFO,
        SRC_BYP
    } src_e;

endpackage

// File: rtl/reg_wr_fifo.sv
// Small holding FIFO for MDU results that lose the write slot to WB.
// Depth must be a power of two so the pointers wrap naturally.
module reg_wr_fifo
    import rw_arb_pkg::*;
#(
    parameter type         T         = rw_result_t,
    parameter int unsigned BUF_DEPTH = 2,
    localparam int unsigned PW       = $clog2(BUF_DEPTH),
    localparam int unsigned CW       = $clog2(BUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  T              wr_data,
    output T              rd_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    T              mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy update; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(BUF_DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register file write port between the WB stage and the MDU,
// and tracks outstanding MDU destinations for decode hazard stalls.
module reg_write_arbiter
    import rw_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = RW_DATA_W,
    parameter int unsigned ADDR_W    = RW_ADDR_W,
    parameter int unsigned NREG      = RW_NREG,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              mdu_valid_i,
    input  logic [ADDR_W-1:0] mdu_addr_i,
    input  logic [DATA_W-1:0] mdu_data_i,
    output logic              mdu_ready_o,
    input  logic              iss_valid_i,
    input  logic [ADDR_W-1:0] iss_addr_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic              hazard_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    output logic [DATA_W-1:0] rf_data_o,
    output logic              err_o
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } res_t;

    res_t            mdu_res;
    res_t            head;
    res_t            sel;
    src_e            src;
    logic            accept;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            err_nxt;

    assign mdu_res     = '{addr: mdu_addr_i, data: mdu_data_i};
    // Ready comes only from registered occupancy, so a drain in the same
    // cycle never reopens a full FIFO.
    assign mdu_ready_o = rst_n_i && !full;
    assign accept      = mdu_valid_i && mdu_ready_o;

    reg_wr_fifo #(
        .T         (res_t),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .push    (push),
        .pop     (pop),
        .wr_data (mdu_res),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Write-slot priority: WB, then queued MDU results, then bypass.
    always_comb begin
        src = SRC_NONE;
        sel = '0;
        if (wb_we_i) begin
            src      = SRC_WB;
            sel.addr = wb_addr_i;
            sel.data = wb_data_i;
        end else if (!empty) begin
            src = SRC_FIFO;
            sel = head;
        end else if (accept) begin
            src = SRC_BYP;
            sel = mdu_res;
        end
    end

    assign push = accept && (src != SRC_BYP);
    assign pop  = (src == SRC_FIFO);

    // Scoreboard next state: clear on MDU write, then set on issue so a
    // same-register issue in the same cycle keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (src == SRC_FIFO || src == SRC_BYP) begin
            busy_nxt[sel.addr] = 1'b0;
        end
        if (iss_valid_i && (iss_addr_i != '0)) begin
            busy_nxt[iss_addr_i] = 1'b1;
        end
    end

    // Sticky protocol-error detection.
    always_comb begin
        err_nxt = err_o
                | (wb_we_i && busy[wb_addr_i])
                | (accept && !busy[mdu_addr_i] && (mdu_addr_i != '0))
                | (iss_valid_i && busy[iss_addr_i]);
    end

    // Registered write port, scoreboard and error flag.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            busy      <= '0;
            err_o     <= 1'b0;
            rf_we_o   <= 1'b0;
            rf_addr_o <= '0;
            rf_data_o <= '0;
        end else begin
            busy      <= busy_nxt;
            err_o     <= err_nxt;
            rf_we_o   <= (src != SRC_NONE) && (sel.addr != '0);
            rf_addr_o <= sel.addr;
            rf_data_o <= sel.data;
        end
    end

    assign hazard_o = rst_n_i && (busy[rs_addr_i] | busy[rt_addr_i]);

    a_count_range : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        count <= CW'(BUF_DEPTH));

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        mdu_valid_i;
    logic [4:0]  mdu_addr_i;
    logic [31:0] mdu_data_i;
    logic        mdu_ready_o;
    logic        iss_valid_i;
    logic [4:0]  iss_addr_i;
    logic [4:0]  rs_addr_i;
    logic [4:0]  rt_addr_i;
    logic        hazard_o;
    logic        rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
    logic        err_o;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_tests = 0;
    int  n_fail  = 0;

    always #5 clk = ~clk;

    reg_write_arbiter dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .wb_we_i     (wb_we_i),
        .wb_addr_i   (wb_addr_i),
        .wb_data_i   (wb_data_i),
        .mdu_valid_i (mdu_valid_i),
        .mdu_addr_i  (mdu_addr_i),
        .mdu_data_i  (mdu_data_i),
        .mdu_ready_o (mdu_ready_o),
        .iss_valid_i (iss_valid_i),
        .iss_addr_i  (iss_addr_i),
        .rs_addr_i   (rs_addr_i),
        .rt_addr_i   (rt_addr_i),
        .hazard_o    (hazard_o),
        .rf_we_o     (rf_we_o),
        .rf_addr_o   (rf_addr_o),
        .rf_data_o   (rf_data_o),
        .err_o       (err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every register-file write must match the next expected write.
    always @(negedge clk) begin
        if (rf_we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got r%0d=0x%0h, expected no write at %0t",
                         rf_addr_o, rf_data_o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", {27'd0, rf_addr_o}, {27'd0, mon_e.a});
                chk("wr_data", rf_data_o, mon_e.d);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        wb_we_i     = 1'b0;
        mdu_valid_i = 1'b0;
        iss_valid_i = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d, input logic expect_write);
        wb_we_i   = 1'b1;
        wb_addr_i = a;
        wb_data_i = d;
        if (expect_write) exp_q.push_back('{a: a, d: d});
    endtask

    task automatic mdu(input logic [4:0] a, input logic [31:0] d);
        mdu_valid_i = 1'b1;
        mdu_addr_i  = a;
        mdu_data_i  = d;
    endtask

    task automatic iss(input logic [4:0] a);
        iss_valid_i = 1'b1;
        iss_addr_i  = a;
    endtask

    task automatic do_reset();
        idle();
        rs_addr_i = '0;
        rt_addr_i = '0;
        rst_n_i   = 1'b0;
        cyc();
        rst_n_i = 1'b1;
    endtask

    initial begin
        wb_addr_i  = '0; wb_data_i  = '0;
        mdu_addr_i = '0; mdu_data_i = '0;
        iss_addr_i = '0;
        do_reset();

        // Reset state
        mid();
        chk("rst_rf_we", {31'd0, rf_we_o}, 0);
        chk("rst_rf_addr", {27'd0, rf_addr_o}, 0);
        chk("rst_rf_data", rf_data_o, 0);
        chk("rst_err", {31'd0, err_o}, 0);
        chk("rst_hazard", {31'd0, hazard_o}, 0);
        chk("rst_ready", {31'd0, mdu_ready_o}, 1);

        // WB alone
        cyc(); wb(5'd5, 32'hDEADBEEF, 1'b1);
        mid(); chk("wb_ready", {31'd0, mdu_ready_o}, 1);
        cyc(); idle();
        mid(); chk("wb_rf_we", {31'd0, rf_we_o}, 1);
        chk("wb_err", {31'd0, err_o}, 0);
        cyc();
        mid(); chk("wb_one_cycle", {31'd0, rf_we_o}, 0);

        // Bypass and scoreboard
        do_reset();
        cyc(); iss(5'd9);
        cyc(); idle(); rs_addr_i = 5'd9;
        mid(); chk("byp_hazard_c1", {31'd0, hazard_o}, 1);
        cyc();
        mid(); chk("byp_hazard_c2", {31'd0, hazard_o}, 1);
        cyc(); mdu(5'd9, 32'h1234); exp_q.push_back('{a: 5'd9, d: 32'h1234});
        mid(); chk("byp_ready_c3", {31'd0, mdu_ready_o}, 1);
        chk("byp_hazard_c3", {31'd0, hazard_o}, 1);
        cyc(); idle();
        mid(); chk("byp_rf_we_c4", {31'd0, rf_we_o}, 1);
        chk("byp_hazard_c4", {31'd0, hazard_o}, 0);
        chk("byp_err", {31'd0, err_o}, 0);

        // Collision and FIFO full
        do_reset();
        rs_addr_i = 5'd3; rt_addr_i = 5'd4;
        cyc(); iss(5'd3);
        cyc(); iss(5'd4);
        cyc(); idle(); wb(5'd10, 32'hA0, 1'b1); mdu(5'd3, 32'h33);
        mid(); chk("col_ready0", {31'd0, mdu_ready_o}, 1);
        chk("col_hazard", {31'd0, hazard_o}, 1);
        cyc(); wb(5'd11, 32'hB0, 1'b1); mdu(5'd4, 32'h44);
        mid(); chk("col_ready1", {31'd0, mdu_ready_o}, 1);
        cyc(); wb(5'd12, 32'hC0, 1'b1); mdu(5'd7, 32'h77);
        mid(); chk("col_full_a", {31'd0, mdu_ready_o}, 0);
        cyc(); wb(5'd13, 32'hD0, 1'b1);
        mid(); chk("col_full_b", {31'd0, mdu_ready_o}, 0);
        cyc(); wb(5'd14, 32'hE0, 1'b1); mdu_valid_i = 1'b0;
        mid(); chk("col_full_c", {31'd0, mdu_ready_o}, 0);
        cyc(); idle();
        exp_q.push_back('{a: 5'd3, d: 32'h33});
        exp_q.push_back('{a: 5'd4, d: 32'h44});
        mid(); chk("col_full_drain", {31'd0, mdu_ready_o}, 0);
        cyc();
        mid(); chk("col_ready_back", {31'd0, mdu_ready_o}, 1);
        chk("col_r3_addr", {27'd0, rf_addr_o}, 3);
        cyc();
        mid(); chk("col_r4_addr", {27'd0, rf_addr_o}, 4);
        chk("col_r4_we", {31'd0, rf_we_o}, 1);
        cyc();
        mid(); chk("col_done_we", {31'd0, rf_we_o}, 0);
        chk("col_hazard_clr", {31'd0, hazard_o}, 0);
        chk("col_err", {31'd0, err_o}, 0);

        // Register 0
        do_reset();
        cyc(); wb(5'd0, 32'h55, 1'b0);
        cyc(); idle(); mdu(5'd0, 32'h66);
        mid(); chk("r0_wb_we", {31'd0, rf_we_o}, 0);
        cyc(); idle(); iss(5'd0);
        mid(); chk("r0_mdu_we", {31'd0, rf_we_o}, 0);
        cyc(); idle();
        mid(); chk("r0_hazard", {31'd0, hazard_o}, 0);
        chk("r0_ready", {31'd0, mdu_ready_o}, 1);
        chk("r0_err", {31'd0, err_o}, 0);

        // Error and same-cycle set/clear
        do_reset();
        rs_addr_i = 5'd6;
        cyc(); iss(5'd6);
        cyc(); idle();
        mid(); chk("err_pre", {31'd0, err_o}, 0);
        chk("err_hazard", {31'd0, hazard_o}, 1);
        cyc(); wb(5'd6, 32'h606, 1'b1);
        cyc(); idle();
        mid(); chk("err_waw", {31'd0, err_o}, 1);
        cyc(); mdu(5'd6, 32'h600); iss(5'd6); exp_q.push_back('{a: 5'd6, d: 32'h600});
        cyc(); idle();
        mid(); chk("setclr_hazard", {31'd0, hazard_o}, 1);
        chk("setclr_we", {31'd0, rf_we_o}, 1);
        cyc(); cyc();
        mid(); chk("err_sticky", {31'd0, err_o}, 1);
        chk("setclr_hold", {31'd0, hazard_o}, 1);

        // Reset mid-operation
        do_reset();
        rs_addr_i = 5'd3;
        cyc(); iss(5'd3);
        cyc(); iss(5'd4);
        cyc(); idle(); wb(5'd20, 32'h2020, 1'b1); mdu(5'd3, 32'h3333);
        cyc(); wb(5'd21, 32'h2121, 1'b1); mdu(5'd4, 32'h4444);
        cyc(); wb(5'd22, 32'h2222, 1'b1); mdu_valid_i = 1'b0;
        mid(); chk("mr_full", {31'd0, mdu_ready_o}, 0);
        chk("mr_hazard_pre", {31'd0, hazard_o}, 1);
        cyc(); idle(); rst_n_i = 1'b0;
        mid(); chk("mr_hazard_in_rst", {31'd0, hazard_o}, 0);
        chk("mr_ready_in_rst", {31'd0, mdu_ready_o}, 0);
        cyc(); rst_n_i = 1'b1;
        mid(); chk("mr_rf_we", {31'd0, rf_we_o}, 0);
        chk("mr_hazard", {31'd0, hazard_o}, 0);
        chk("mr_err", {31'd0, err_o}, 0);
        chk("mr_ready", {31'd0, mdu_ready_o}, 1);
        for (int i = 0; i < 5; i++) cyc();
        mid();

        chk("all_writes_seen", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
